watchdog_reset_ctrl: RTL and testbench



---
 rtl/watchdog_reset_ctrl.sv | 122 ++++++++++++
 tb/tb_watchdog_reset_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watchdog_reset_ctrl.sv
// Watchdog reset controller: turns the watchdog timeout level into a warning
// interrupt, a grace period, a fixed-width system reset pulse and a final lockout.
module watchdog_reset_ctrl #(
  parameter int unsigned GRACE_CYCLES     = 1024,
  parameter int unsigned RST_PULSE_CYCLES = 16,
  parameter int unsigned MAX_RESETS       = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       timeout_i,
  input  logic       cancel_i,
  input  logic       cause_clear_i,
  output logic       irq_o,
  output logic       sys_reset_o,
  output logic       halt_o,
  output logic       wdt_cause_o,
  output logic [3:0] reset_count_o,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WARN  = 3'd1,
    ST_RESET = 3'd2,
    ST_HOLD  = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  localparam logic [23:0] GRACE_LOAD = 24'(GRACE_CYCLES - 1);
  localparam logic [23:0] PULSE_LOAD = 24'(RST_PULSE_CYCLES - 1);
  localparam logic [4:0]  MAX_LIMIT  = 5'(MAX_RESETS);

  state_e      state_q, state_d;
  logic [23:0] ctr_q, ctr_d;
  logic [3:0]  count_q, count_d;
  logic        cause_q, cause_d;
  logic [3:0]  count_inc;
  logic        last_allowed;

  // The counter saturates; the halt decision uses a 5-bit sum so 15+1 cannot wrap.
  assign count_inc    = (count_q == 4'hF) ? 4'hF : count_q + 4'd1;
  assign last_allowed = ({1'b0, count_q} + 5'd1) >= MAX_LIMIT;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      ctr_q   <= '0;
      count_q <= '0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      count_q <= count_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    count_d = count_q;
    cause_d = cause_q;

    // A clear is applied first so an increment in the same cycle overrides it.
    if (cause_clear_i && (state_q != ST_HALT)) begin
      count_d = '0;
      cause_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (timeout_i) begin
          state_d = ST_WARN;
          ctr_d   = GRACE_LOAD;
        end
      end
      ST_WARN: begin
        if (cancel_i) begin
          state_d = ST_IDLE;
        end else if (ctr_q == '0) begin
          count_d = count_inc;
          cause_d = 1'b1;
          if (last_allowed) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_RESET;
            ctr_d   = PULSE_LOAD;
          end
        end else begin
          ctr_d = ctr_q - 24'd1;
        end
      end
      ST_RESET: begin
        if (ctr_q == '0) begin
          state_d = ST_HOLD;
        end else begin
          ctr_d = ctr_q - 24'd1;
        end
      end
      ST_HOLD: begin
        // A timeout still high here is the old event, not a new one.
        if (!timeout_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign irq_o         = (state_q == ST_WARN);
  assign sys_reset_o   = (state_q == ST_RESET) || (state_q == ST_HALT);
  assign halt_o        = (state_q == ST_HALT);
  assign wdt_cause_o   = cause_q;
  assign reset_count_o = count_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_watchdog_reset_ctrl.sv
// Directed bench for watchdog_reset_ctrl: three instances cover the default
// configuration, an early halt limit, and single-cycle grace/pulse timing.
module tb_watchdog_reset_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WARN  = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] timeout = '0;
  logic [2:0] cancel = '0;
  logic [2:0] cause_clear = '0;
  logic [2:0] irq, sys_reset, halt, wdt_cause;
  logic [3:0] reset_count [3];
  logic [2:0] dbg_state [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // inst 0: defaults
  watchdog_reset_ctrl u_dut0 (
    .clk_i(clk), .reset_i(reset), .timeout_i(timeout[0]), .cancel_i(cancel[0]),
    .cause_clear_i(cause_clear[0]), .irq_o(irq[0]), .sys_reset_o(sys_reset[0]),
    .halt_o(halt[0]), .wdt_cause_o(wdt_cause[0]), .reset_count_o(reset_count[0]),
    .dbg_state_o(dbg_state[0])
  );

  // inst 1: halt after two watchdog resets
  watchdog_reset_ctrl #(.MAX_RESETS(2)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .timeout_i(timeout[1]), .cancel_i(cancel[1]),
    .cause_clear_i(cause_clear[1]), .irq_o(irq[1]), .sys_reset_o(sys_reset[1]),
    .halt_o(halt[1]), .wdt_cause_o(wdt_cause[1]), .reset_count_o(reset_count[1]),
    .dbg_state_o(dbg_state[1])
  );

  // inst 2: one-cycle grace and pulse, 15-reset limit
  watchdog_reset_ctrl #(.GRACE_CYCLES(1), .RST_PULSE_CYCLES(1), .MAX_RESETS(15)) u_dut2 (
    .clk_i(clk), .reset_i(reset), .timeout_i(timeout[2]), .cancel_i(cancel[2]),
    .cause_clear_i(cause_clear[2]), .irq_o(irq[2]), .sys_reset_o(sys_reset[2]),
    .halt_o(halt[2]), .wdt_cause_o(wdt_cause[2]), .reset_count_o(reset_count[2]),
    .dbg_state_o(dbg_state[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  // Number of consecutive samples irq stays high, starting from the current one.
  task automatic count_irq(input int idx, output int n);
    n = 0;
    while (irq[idx] === 1'b1 && n < 5000) begin
      n++;
      step(1);
    end
  endtask

  task automatic count_sys(input int idx, output int n);
    n = 0;
    while (sys_reset[idx] === 1'b1 && n < 5000) begin
      n++;
      step(1);
    end
  endtask

  // One complete fast sequence on inst 2, ending back in IDLE.
  task automatic run_fast();
    timeout[2] = 1'b1;
    step(3);
    timeout[2] = 1'b0;
    step(1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    logic seen;

    step(2);
    reset = 1'b0;
    check("rst_irq", irq[0], 1'b0);
    check("rst_sys", sys_reset[0], 1'b0);
    check("rst_halt", halt[0], 1'b0);
    check("rst_cause", wdt_cause[0], 1'b0);
    check("rst_count", reset_count[0], 4'd0);
    check("rst_state", dbg_state[0], S_IDLE);

    // Full default sequence, timeout dropped during the pulse
    step(8);
    timeout[0] = 1'b1;
    check("a_irq_before_edge", irq[0], 1'b0);
    step(1);
    check("a_irq_latency", irq[0], 1'b1);
    count_irq(0, n);
    check("a_irq_len", n, 1024);
    check("a_sys_same_edge", sys_reset[0], 1'b1);
    check("a_count", reset_count[0], 4'd1);
    check("a_cause", wdt_cause[0], 1'b1);
    timeout[0] = 1'b0;
    count_sys(0, n);
    check("a_pulse_len", n, 16);
    check("a_hold", dbg_state[0], S_HOLD);
    step(1);
    check("a_idle", dbg_state[0], S_IDLE);

    // Cancel 100 cycles into WARN
    do_reset();
    timeout[0] = 1'b1;
    step(101);
    check("b_in_warn", irq[0], 1'b1);
    cancel[0] = 1'b1;
    timeout[0] = 1'b0;
    step(1);
    cancel[0] = 1'b0;
    check("b_irq_drop", irq[0], 1'b0);
    check("b_state", dbg_state[0], S_IDLE);
    seen = 1'b0;
    repeat (1100) begin
      step(1);
      seen = seen | sys_reset[0];
    end
    check("b_no_sys", seen, 1'b0);
    check("b_count", reset_count[0], 4'd0);

    // Cancel on the final WARN cycle beats expiry
    timeout[0] = 1'b1;
    step(1024);
    check("b_last_warn", irq[0], 1'b1);
    cancel[0] = 1'b1;
    timeout[0] = 1'b0;
    step(1);
    cancel[0] = 1'b0;
    check("b_last_irq", irq[0], 1'b0);
    check("b_last_sys", sys_reset[0], 1'b0);
    check("b_last_state", dbg_state[0], S_IDLE);
    check("b_last_count", reset_count[0], 4'd0);
    check("b_last_cause", wdt_cause[0], 1'b0);

    // Timeout held high after the pulse stays in HOLD
    timeout[0] = 1'b1;
    step(1);
    count_irq(0, n);
    count_sys(0, n);
    check("d_hold_entry", dbg_state[0], S_HOLD);
    step(20);
    check("d_hold_stay", dbg_state[0], S_HOLD);
    check("d_no_irq", irq[0], 1'b0);
    timeout[0] = 1'b0;
    step(1);
    check("d_idle", dbg_state[0], S_IDLE);
    step(3);
    check("d_no_rearm", irq[0], 1'b0);
    timeout[0] = 1'b1;
    step(1);
    check("d_rearm", irq[0], 1'b1);
    check("d_count", reset_count[0], 4'd1);
    cancel[0] = 1'b1;
    timeout[0] = 1'b0;
    step(1);
    cancel[0] = 1'b0;

    // MAX_RESETS=2: second expiry halts
    do_reset();
    timeout[1] = 1'b1;
    step(1);
    count_irq(1, n);
    check("c_irq_len1", n, 1024);
    count_sys(1, n);
    check("c_pulse_len", n, 16);
    check("c_count1", reset_count[1], 4'd1);
    timeout[1] = 1'b0;
    step(1);
    check("c_idle", dbg_state[1], S_IDLE);
    timeout[1] = 1'b1;
    step(1);
    count_irq(1, n);
    check("c_irq_len2", n, 1024);
    check("c_halt", halt[1], 1'b1);
    check("c_halt_sys", sys_reset[1], 1'b1);
    check("c_halt_state", dbg_state[1], S_HALT);
    check("c_count2", reset_count[1], 4'd2);
    cause_clear[1] = 1'b1;
    step(1);
    cause_clear[1] = 1'b0;
    check("c_clear_ign_count", reset_count[1], 4'd2);
    check("c_clear_ign_cause", wdt_cause[1], 1'b1);
    timeout[1] = 1'b0;
    step(100);
    check("c_halt_stays", halt[1], 1'b1);
    check("c_sys_stays", sys_reset[1], 1'b1);
    do_reset();
    check("c_rst_halt", halt[1], 1'b0);
    check("c_rst_sys", sys_reset[1], 1'b0);
    check("c_rst_count", reset_count[1], 4'd0);
    check("c_rst_cause", wdt_cause[1], 1'b0);
    check("c_rst_state", dbg_state[1], S_IDLE);

    // One-cycle grace and pulse
    timeout[2] = 1'b1;
    step(1);
    check("e_irq", irq[2], 1'b1);
    step(1);
    check("e_irq_fall", irq[2], 1'b0);
    check("e_sys", sys_reset[2], 1'b1);
    step(1);
    check("e_sys_fall", sys_reset[2], 1'b0);
    check("e_hold", dbg_state[2], S_HOLD);
    timeout[2] = 1'b0;
    step(1);
    run_fast();
    run_fast();
    check("e_count3", reset_count[2], 4'd3);

    // Clear coinciding with the increment: increment wins
    timeout[2] = 1'b1;
    step(1);
    check("e_warn4", dbg_state[2], S_WARN);
    cause_clear[2] = 1'b1;
    step(1);
    cause_clear[2] = 1'b0;
    check("e_coinc_count", reset_count[2], 4'd4);
    check("e_coinc_cause", wdt_cause[2], 1'b1);
    step(1);
    timeout[2] = 1'b0;
    cause_clear[2] = 1'b1;
    step(1);
    cause_clear[2] = 1'b0;
    check("e_clear_count", reset_count[2], 4'd0);
    check("e_clear_cause", wdt_cause[2], 1'b0);
    check("e_clear_state", dbg_state[2], S_IDLE);

    // Cancel in a one-cycle WARN
    timeout[2] = 1'b1;
    step(1);
    cancel[2] = 1'b1;
    timeout[2] = 1'b0;
    step(1);
    cancel[2] = 1'b0;
    check("e_cancel_state", dbg_state[2], S_IDLE);
    check("e_cancel_sys", sys_reset[2], 1'b0);
    check("e_cancel_count", reset_count[2], 4'd0);

    // Climb to the 15-reset limit
    repeat (14) run_fast();
    check("e_count14", reset_count[2], 4'd14);
    check("e_not_halt", halt[2], 1'b0);
    timeout[2] = 1'b1;
    step(2);
    check("e_halt15", halt[2], 1'b1);
    check("e_count15", reset_count[2], 4'd15);
    step(10);
    check("e_count_sat", reset_count[2], 4'd15);
    timeout[2] = 1'b0;
    do_reset();
    check("e_rst_halt", halt[2], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
